// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two line buffers feed a 3x3 tap array,
// flagging each complete window one cycle after the pixel that closes it.
module window_gen_3x3 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDHT-1:0] Data_Out0,
  output logic [DATA_WIDHT-1:0] Data_Out1,
  output logic [DATA_WIDHT-1:0] Data_Out2,
  output logic [DATA_WIDHT-1:0] Data_Out3,
  output logic [DATA_WIDHT-1:0] Data_Out4,
  output logic [DATA_WIDHT-1:0] Data_Out5,
  output logic [DATA_WIDHT-1:0] Data_Out6,
  output logic [DATA_WIDHT-1:0] Data_Out7,
  output logic [DATA_WIDHT-1:0] Data_Out8,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]         col_r;
  logic [RW-1:0]         row_r;
  logic [DATA_WIDHT-1:0] line0_r [IMG_W];
  logic [DATA_WIDHT-1:0] line1_r [IMG_W];
  logic [DATA_WIDHT-1:0] top_r [3];
  logic [DATA_WIDHT-1:0] mid_r [3];
  logic [DATA_WIDHT-1:0] bot_r [3];
  logic [DATA_WIDHT-1:0] line0_rd_s;
  logic [DATA_WIDHT-1:0] line1_rd_s;
  logic                  col_wrap_s;
  logic                  frame_end_s;
  logic                  win_hit_s;
  logic                  valid_r;
  logic                  done_r;

  // With STRIDE 2 the window origin (pos-2) lands on even positions only.
  function automatic logic on_stride(input logic pos_lsb);
    if (STRIDE == 2) begin
      on_stride = (pos_lsb == 1'b0);
    end else begin
      on_stride = 1'b1;
    end
  endfunction

  // Line-buffer reads, wrap detection and window condition for the current pixel position.
  always_comb begin
    line0_rd_s  = line0_r[col_r];
    line1_rd_s  = line1_r[col_r];
    col_wrap_s  = (col_r == COL_LAST);
    frame_end_s = col_wrap_s && (row_r == ROW_LAST);
    win_hit_s   = 1'b0;
    if ((row_r >= ROW_TWO) && (col_r >= COL_TWO)) begin
      win_hit_s = on_stride(row_r[0]) && on_stride(col_r[0]);
    end else begin
      win_hit_s = 1'b0;
    end
  end

  // Raster position counters; both wrap together at the frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (Valid_In) begin
      if (col_wrap_s) begin
        col_r <= '0;
        row_r <= (row_r == ROW_LAST) ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Line buffers are never cleared; the window condition keeps stale entries hidden.
  always_ff @(posedge clk) begin
    if (Valid_In) begin
      line1_r[col_r] <= line0_rd_s;
      line0_r[col_r] <= Data_In;
    end
  end

  // Tap array shifts left on each accepted pixel; strobes are registered alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        top_r[i] <= '0;
        mid_r[i] <= '0;
        bot_r[i] <= '0;
      end
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      valid_r <= Valid_In && win_hit_s;
      done_r  <= Valid_In && frame_end_s;
      if (Valid_In) begin
        for (int i = 0; i < 2; i++) begin
          top_r[i] <= top_r[i+1];
          mid_r[i] <= mid_r[i+1];
          bot_r[i] <= bot_r[i+1];
        end
        top_r[2] <= line1_rd_s;
        mid_r[2] <= line0_rd_s;
        bot_r[2] <= Data_In;
      end
    end
  end

  assign Data_Out0  = top_r[0];
  assign Data_Out1  = top_r[1];
  assign Data_Out2  = top_r[2];
  assign Data_Out3  = mid_r[0];
  assign Data_Out4  = mid_r[1];
  assign Data_Out5  = mid_r[2];
  assign Data_Out6  = bot_r[0];
  assign Data_Out7  = bot_r[1];
  assign Data_Out8  = bot_r[2];
  assign Valid_Out  = valid_r;
  assign Frame_Done = done_r;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 4x4 stride-1 instance and a 5x5 stride-2 instance.
module tb_window_gen_3x3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din1, din2;
  logic        vin1, vin2;
  logic [31:0] t1 [9];
  logic [31:0] t2 [9];
  logic        vo1, vo2, fd1, fd2;
  logic [31:0] exp9 [9];
  logic [31:0] last_center;
  logic        have_center;
  int          total = 0;
  int          bad = 0;
  int          pulses;

  always #5 clk = ~clk;

  window_gen_3x3 #(.DATA_WIDHT(32), .IMG_W(4), .IMG_H(4), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .Data_In(din1), .Valid_In(vin1),
    .Data_Out0(t1[0]), .Data_Out1(t1[1]), .Data_Out2(t1[2]),
    .Data_Out3(t1[3]), .Data_Out4(t1[4]), .Data_Out5(t1[5]),
    .Data_Out6(t1[6]), .Data_Out7(t1[7]), .Data_Out8(t1[8]),
    .Valid_Out(vo1), .Frame_Done(fd1)
  );

  window_gen_3x3 #(.DATA_WIDHT(32), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .Data_In(din2), .Valid_In(vin2),
    .Data_Out0(t2[0]), .Data_Out1(t2[1]), .Data_Out2(t2[2]),
    .Data_Out3(t2[3]), .Data_Out4(t2[4]), .Data_Out5(t2[5]),
    .Data_Out6(t2[6]), .Data_Out7(t2[7]), .Data_Out8(t2[8]),
    .Valid_Out(vo2), .Frame_Done(fd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Push one pixel into the 4x4 stride-1 instance; idx is its position in the frame.
  task automatic push1(input int val, input int idx);
    int  r, c, base;
    logic ev;
    din1 = val;
    vin1 = 1'b1;
    @(posedge clk); #1;
    vin1 = 1'b0;
    r = idx / 4; c = idx % 4; base = val - idx;
    ev = (r >= 2) && (c >= 2);
    chk($sformatf("s1_valid_px%0d", val), {31'd0, vo1}, {31'd0, ev});
    chk($sformatf("s1_done_px%0d", val), {31'd0, fd1}, {31'd0, (idx == 15)});
    have_center = ev;
    if (ev) begin
      pulses++;
      for (int k = 0; k < 9; k++)
        chk($sformatf("s1_tap%0d_px%0d", k, val), t1[k],
            32'(base + (r - 2 + k / 3) * 4 + (c - 2 + k % 3)));
      last_center = 32'(base + (r - 1) * 4 + (c - 1));
    end
  endtask

  // Idle cycles on the 4x4 instance: strobes low, taps held.
  task automatic idle1(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      chk("s1_idle_valid", {31'd0, vo1}, 32'd0);
      chk("s1_idle_done", {31'd0, fd1}, 32'd0);
      if (have_center) chk("s1_idle_hold", t1[4], last_center);
    end
  endtask

  // Push one pixel into the 5x5 stride-2 instance.
  task automatic push2(input int val, input int idx);
    int  r, c;
    logic ev;
    din2 = val;
    vin2 = 1'b1;
    @(posedge clk); #1;
    vin2 = 1'b0;
    r = idx / 5; c = idx % 5;
    ev = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
    chk($sformatf("s2_valid_px%0d", val), {31'd0, vo2}, {31'd0, ev});
    chk($sformatf("s2_done_px%0d", val), {31'd0, fd2}, {31'd0, (idx == 24)});
    if (ev) pulses++;
  endtask

  task automatic chk_taps1(input string tag);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_%0d", tag, k), t1[k], exp9[k]);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_v1"}, {31'd0, vo1}, 32'd0);
    chk({tag, "_f1"}, {31'd0, fd1}, 32'd0);
    chk({tag, "_v2"}, {31'd0, vo2}, 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_t1_%0d", tag, k), t1[k], 32'd0);
  endtask

  initial begin
    rst = 1'b0; din1 = 32'd0; din2 = 32'd0; vin1 = 1'b0; vin2 = 1'b0;
    have_center = 1'b0; last_center = 32'd0; pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    for (int k = 0; k < 9; k++) chk($sformatf("reset_t2_%0d", k), t2[k], 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: one 4x4 frame, stride 1
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push1(i, i);
      if (i == 10) begin
        exp9 = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd8, 32'd9, 32'd10};
        chk_taps1("t1_first");
      end
    end
    exp9 = '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10, 32'd11, 32'd13, 32'd14, 32'd15};
    chk_taps1("t1_last");
    chk("t1_pulses", 32'(pulses), 32'd4);

    // T3: same frame with three idle cycles after every pixel
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      push1(i, i);
      idle1(3);
    end
    chk("t3_pulses", 32'(pulses), 32'd4);

    // T4: two frames back to back
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      push1(i, i % 16);
      if (i == 26) begin
        exp9 = '{32'd16, 32'd17, 32'd18, 32'd20, 32'd21, 32'd22, 32'd24, 32'd25, 32'd26};
        chk_taps1("t4_f2_first");
      end
    end
    chk("t4_pulses", 32'(pulses), 32'd8);

    // T5: reset after pixel 9, then a fresh frame with distinct data
    for (int i = 0; i < 10; i++) push1(i, i);
    rst = 1'b0;
    #1;
    chk_reset_outs("t5_rst_now");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("t5_rst_held");
    rst = 1'b1;
    have_center = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) push1(i + 100, i);
    chk("t5_pulses", 32'(pulses), 32'd4);

    // T2: 5x5 frame, stride 2
    pulses = 0;
    for (int i = 0; i < 25; i++) push2(i, i);
    chk("t2_pulses", 32'(pulses), 32'd4);
    exp9 = '{32'd12, 32'd13, 32'd14, 32'd17, 32'd18, 32'd19, 32'd22, 32'd23, 32'd24};
    for (int k = 0; k < 9; k++) chk($sformatf("t2_last_%0d", k), t2[k], exp9[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
